// File: rtl/rv32i_types.sv
// rv32i_types: shared opcode encoding plus the predictor record types used by branch_resolve_unit.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_pred_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        is_br;
  } br_update_t;
  typedef enum logic {RUN, RECOVER} bru_state_e;
endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: generic FIFO with clear; pushes at full are accepted only alongside a real pop.
module pred_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == (AW+1)'(DEPTH);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rd_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks IF predictions against MEM outcomes, flushes on mispredict, buffers table updates.
// Optional saturating perf counters are built only when BR_PERF_CNT_EN is defined.
import rv32i_types::*;
module branch_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int UPD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_push,
  input  logic        if_pred_taken,
  input  logic [31:0] if_pred_target,
  input  logic        mem_resolve,
  input  rv32i_opcode mem_opcode,
  input  logic [31:0] mem_pc,
  input  logic        br_en,
  input  logic [31:0] calculated_addr,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_is_br,
  output logic        q_overflow,
  output logic [31:0] ctrl_cnt,
  output logic [31:0] mispred_cnt,
  output logic [31:0] drop_cnt
);
  bru_state_e  state_q;
  logic        flush_q, ovf_q;
  logic [31:0] redirect_q;
  br_pred_t    pred_wdata, pred_rdata, pred;
  br_update_t  upd_wdata, upd_rdata, upd;
  logic        pred_full, pred_empty, upd_full, upd_empty;
  logic        run, push, resolve, is_br, actual_taken, mispred, xfer, upd_push;
  logic [31:0] correct_pc;
  always_comb begin
    run          = state_q == RUN;
    push         = run && if_push;
    resolve      = run && mem_resolve;
    pred         = pred_empty ? '0 : pred_rdata;
    is_br        = mem_opcode == op_br;
    actual_taken = is_br ? br_en : 1'b1;
    correct_pc   = actual_taken ? calculated_addr : mem_pc + 32'd4;
    mispred      = resolve && (pred.taken != actual_taken || (actual_taken && pred.target != calculated_addr));
    xfer         = !upd_empty && upd_ready;
    upd_push     = resolve && (!upd_full || xfer);
    pred_wdata   = '{taken: if_pred_taken, target: if_pred_target};
    upd_wdata    = '{pc: mem_pc, target: calculated_addr, taken: actual_taken, is_br: is_br};
    upd          = upd_empty ? '0 : upd_rdata;
  end
  pred_fifo #(.W($bits(br_pred_t)), .DEPTH(DEPTH)) u_pred_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(resolve), .clear(mispred),
    .wdata(pred_wdata), .rdata(pred_rdata), .full(pred_full), .empty(pred_empty)
  );
  pred_fifo #(.W($bits(br_update_t)), .DEPTH(UPD_DEPTH)) u_upd_fifo (
    .clk(clk), .rst_n(rst_n), .push(upd_push), .pop(xfer), .clear(1'b0),
    .wdata(upd_wdata), .rdata(upd_rdata), .full(upd_full), .empty(upd_empty)
  );
  // RECOVER is the single wrong-path cycle; mispred can never fire there since resolve is gated by run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= mispred ? RECOVER : RUN;
      flush_q <= mispred;
      if (mispred) redirect_q <= correct_pc;
      if (push && pred_full && !resolve) ovf_q <= 1'b1;
    end
  end
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign q_overflow  = ovf_q;
  assign upd_valid   = !upd_empty;
  assign upd_pc      = upd.pc;
  assign upd_target  = upd.target;
  assign upd_taken   = upd.taken;
  assign upd_is_br   = upd.is_br;
`ifdef BR_PERF_CNT_EN
  logic [31:0] ctrl_q, mis_q, drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      mis_q  <= '0;
      drop_q <= '0;
    end else begin
      if (resolve && ~&ctrl_q) ctrl_q <= ctrl_q + 32'd1;
      if (mispred && ~&mis_q) mis_q <= mis_q + 32'd1;
      if (resolve && !upd_push && ~&drop_q) drop_q <= drop_q + 32'd1;
    end
  end
  assign ctrl_cnt    = ctrl_q;
  assign mispred_cnt = mis_q;
  assign drop_cnt    = drop_q;
`else
  assign ctrl_cnt    = '0;
  assign mispred_cnt = '0;
  assign drop_cnt    = '0;
`endif
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution end of the fetch-side branch predictor. Records the prediction made in IF for every branch/jump entering the pipe and compares it with the actual outcome in MEM. On mismatch, issues a registered flush plus redirect PC. Emits buffered BTB/BHT update transactions that the predictor tables consume.

## Interface
- `DEPTH`, default 4: prediction FIFO entries (in-flight control instructions IF..MEM); power of two.
- `UPD_DEPTH`, default 2: update buffer entries; power of two.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_push` in 1: control op (op_br/op_jal/op_jalr) leaves IF this cycle.
- `if_pred_taken` in 1: prediction given to the fetch mux.
- `if_pred_target` in 32: predicted target.
- `mem_resolve` in 1: control op valid in MEM this cycle.
- `mem_opcode` in rv32i_opcode: MEM opcode.
- `mem_pc` in 32: PC of the MEM instruction.
- `br_en` in 1: branch condition result.
- `calculated_addr` in 32: computed target (alu_mem).
- `flush` out 1: kill IF..EX, registered pulse.
- `redirect_pc` out 32: correct next PC, valid with `flush`.
- `upd_valid` out 1, `upd_ready` in 1: update handshake.
- `upd_pc`, `upd_target` out 32; `upd_taken`, `upd_is_br` out 1: update payload.
- `q_overflow` out 1: sticky, push seen while FIFO full.
- `ctrl_cnt`, `mispred_cnt`, `drop_cnt` out 32 each: perf counters (see Configuration).

## Operation
- States: RUN, RECOVER. Reset → RUN.
- RUN, `if_push`: write {pred_taken, pred_target} at FIFO tail.
- RUN, `mem_resolve`: pop head. If the FIFO is empty, use {0, 0}.
- actual_taken = 1 for op_jal/op_jalr, `br_en` for op_br.
- correct_pc = actual_taken ? `calculated_addr` : `mem_pc`+4, mod 2^32.
- Mispredict = pred_taken != actual_taken, or (actual_taken and pred_target != `calculated_addr`).
- On mispredict:
  - Register `flush`=1 and `redirect_pc`=correct_pc for the next cycle.
  - Go to RECOVER.
  - Clear the FIFO at that edge, overriding any same-cycle push.
- RECOVER lasts exactly one cycle:
  - `flush` is high.
  - `if_push` and `mem_resolve` are ignored (wrong path).
  - Returns to RUN.
- Every RUN resolve, correct or not, enqueues an update: {`mem_pc`, `calculated_addr`, actual_taken, opcode==op_br}.
- Update buffer full with no pop this cycle: the update is dropped and `drop_cnt` increments.
- Push and pop in the same cycle are legal at any occupancy, including full. Count is unchanged.
- Push while full with no pop: push is dropped and `q_overflow` is set. Cleared only by reset.

## Timing
- Reset values:
  - `flush`=0, `redirect_pc`=0, `upd_valid`=0.
  - `upd_*` payload=0, `q_overflow`=0, counters=0.
  - FIFOs empty, state RUN.
- Mispredict resolved in cycle N → `flush` and `redirect_pc` in N+1 only.
- Update from a resolve in cycle N → `upd_valid` no earlier than N+1.
- Payload stays stable while `upd_valid` && !`upd_ready`. Transfer happens when both are high.
- `upd_valid` is never combinationally dependent on `upd_ready`.
- Asynchronous reset mid-RECOVER or mid-handshake: all state goes to reset values immediately. Pending updates are lost.

## Configuration
- `BR_PERF_CNT_EN` defined:
  - `ctrl_cnt` increments per accepted resolve.
  - `mispred_cnt` increments per mispredict.
  - `drop_cnt` increments per dropped update.
  - All three saturate at 2^32-1.
- `BR_PERF_CNT_EN` undefined: the three counters are tied to 0 and no counter flops exist.

## Structure
- Add `br_pred_t` {taken, target} and `br_update_t` {pc, target, taken, is_br} to `rv32i_types`.
- One parameterized sub-module, `pred_fifo`: width/depth generic, push/pop/clear, full/empty. Instantiate it twice, for predictions and updates.

## Test plan
- Push {1, 0x100} for the jal at 0x40. Resolve with `calculated_addr`=0x100 → no `flush`, and one update {0x40, 0x100, 1, 0}.
- Push {0, 0} for op_br at 0x80. Resolve with `br_en`=1, `calculated_addr`=0x200 → `flush`=1 for one cycle next cycle, `redirect_pc`=0x200, FIFO empty afterwards.
- Push {1, 0x300} for op_br at 0x90. Resolve with `br_en`=0 → `redirect_pc`=0x94.
- Push 4 entries and a 5th in the same cycle as a pop → no overflow. Then a 5th push without a pop → `q_overflow`=1 and the push is dropped.
- Hold `upd_ready`=0 across 3 resolves → 2 buffered, `drop_cnt`=1 (macro on) or 0 (macro off), payload stable.
- Assert `rst_n`=0 during the RECOVER cycle → `flush`=0 immediately, all outputs at reset values.
